// File: rtl/cmd_frame_parser.sv
// Pulls SYNC/opcode/addr/data bytes from a first-word fall-through FIFO and issues one register request per frame.
// Request rises one cycle after the last frame byte pops; FIFO is not popped while a request waits for reg_ack.
module cmd_frame_parser #(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_valid,
  output logic        fifo_rd_en,
  output logic        reg_req,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [7:0] OP_WR       = 8'h01;
  localparam logic [7:0] OP_RD       = 8'h02;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, ISSUE} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    byte_idx;
  logic          timed;
  logic          tmo_hit;

  assign fifo_rd_en = fifo_valid && (state != ISSUE);
  assign timed      = (state == OPCODE) || (state == ADDR) || (state == DATA);
  // Fires on the edge that would take the idle count to TIMEOUT_CYCLES.
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      byte_idx  <= '0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fifo_rd_en) tmo_cnt <= '0;

      case (state)
        IDLE: begin
          if (fifo_valid && (fifo_rd_data == SYNC_BYTE)) begin
            state <= OPCODE;
            busy  <= 1'b1;
          end
        end
        OPCODE: begin
          if (fifo_valid) begin
            if (fifo_rd_data == OP_WR) begin
              reg_we <= 1'b1;
              state  <= ADDR;
            end else if (fifo_rd_data == OP_RD) begin
              reg_we <= 1'b0;
              state  <= ADDR;
            end else if (fifo_rd_data != SYNC_BYTE) begin
              frame_err <= 1'b1;
              err_code  <= ERR_OPCODE;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        ADDR: begin
          if (fifo_valid) begin
            reg_addr <= fifo_rd_data;
            if (reg_we) begin
              byte_idx <= 2'd0;
              state    <= DATA;
            end else begin
              reg_wdata <= '0;
              reg_req   <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DATA: begin
          if (fifo_valid) begin
            reg_wdata <= {reg_wdata[23:0], fifo_rd_data};
            byte_idx  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              reg_req <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (reg_ack) begin
            reg_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // In the collecting states a cycle without a pop is exactly an idle cycle.
      if (timed && !fifo_valid) begin
        if (tmo_hit) begin
          frame_err <= 1'b1;
          err_code  <= ERR_TIMEOUT;
          state     <= IDLE;
          busy      <= 1'b0;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed vectors plus hand-written timeout, reset and back-pressure sequences for cmd_frame_parser.
module tb_cmd_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifo_rd_data;
  logic        fifo_valid;
  logic        fifo_rd_en;
  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int nerr = 0;
  int ncheck = 0;

  cmd_frame_parser #(.TIMEOUT_CYCLES(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .fifo_rd_data(fifo_rd_data), .fifo_valid(fifo_valid),
    .fifo_rd_en(fifo_rd_en), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_ack(reg_ack), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v; logic [7:0] d; logic ack;
    logic rd_en, req, chk, we; logic [7:0] addr; logic [31:0] wd;
    logic err; logic [1:0] code; logic busy;
  } vec_t;

  vec_t     vecs[$];
  logic [7:0] q[$];

  function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic a,
                              input logic rd, rq, ck, we, input logic [7:0] ad,
                              input logic [31:0] wd, input logic er,
                              input logic [1:0] cd, input logic bz);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.ack = a; t.rd_en = rd; t.req = rq; t.chk = ck;
    t.we = we; t.addr = ad; t.wd = wd; t.err = er; t.code = cd; t.busy = bz;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic qstep();
    logic pop;
    pop = fifo_valid && fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    fifo_valid   = (q.size() != 0);
    fifo_rd_data = fifo_valid ? q[0] : 8'h00;
    #1;
  endtask

  task automatic wait_err(input string nm, input int exp_k);
    int k;
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (frame_err === 1'b1) begin
        k = i;
        break;
      end
    end
    chk({nm, "_edges"}, k, exp_k);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; fifo_valid = 1'b0; fifo_rd_data = 8'h00; reg_ack = 1'b0;

    // rst v d ack | rd_en req chk we addr wdata err code busy
    vecs.push_back(mk(1,0,8'h00,0, 0,0,1,0,8'h00,32'h0,0,2'd0,0));
    vecs.push_back(mk(1,1,8'hA5,0, 1,0,1,0,8'h00,32'h0,0,2'd0,0));
    vecs.push_back(mk(0,0,8'h00,0, 0,0,1,0,8'h00,32'h0,0,2'd0,0));
    // write A5 01 10 DE AD BE EF, ack in the third request cycle
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h01,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h10,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hDE,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hAD,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hBE,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hEF,0, 1,1,1,1,8'h10,32'hDEADBEEF,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hA5,0, 0,1,1,1,8'h10,32'hDEADBEEF,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hA5,0, 0,1,1,1,8'h10,32'hDEADBEEF,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hA5,1, 0,0,0,0,8'h00,32'h0,0,2'd0,0));
    // read A5 02 3C with a one-cycle request
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h02,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h3C,0, 1,1,1,0,8'h3C,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,0,8'h00,1, 0,0,0,0,8'h00,32'h0,0,2'd0,0));
    // garbage, then resync A5 A5 01 20 00 00 00 05
    vecs.push_back(mk(0,1,8'h00,0, 1,0,0,0,8'h00,32'h0,0,2'd0,0));
    vecs.push_back(mk(0,1,8'hFF,0, 1,0,0,0,8'h00,32'h0,0,2'd0,0));
    vecs.push_back(mk(0,1,8'h12,0, 1,0,0,0,8'h00,32'h0,0,2'd0,0));
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h01,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h20,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h00,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h00,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h00,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h05,0, 1,1,1,1,8'h20,32'h00000005,0,2'd0,1));
    vecs.push_back(mk(0,0,8'h00,1, 0,0,0,0,8'h00,32'h0,0,2'd0,0));
    // bad opcode A5 07, then A5 02 01
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,0,0,8'h00,32'h0,0,2'd0,1));
    vecs.push_back(mk(0,1,8'h07,0, 1,0,0,0,8'h00,32'h0,1,2'd1,0));
    vecs.push_back(mk(0,1,8'hA5,0, 1,0,0,0,8'h00,32'h0,0,2'd1,1));
    vecs.push_back(mk(0,1,8'h02,0, 1,0,0,0,8'h00,32'h0,0,2'd1,1));
    vecs.push_back(mk(0,1,8'h01,0, 1,1,1,0,8'h01,32'h0,0,2'd1,1));
    vecs.push_back(mk(0,0,8'h00,1, 0,0,0,0,8'h00,32'h0,0,2'd1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; fifo_valid = vecs[i].v; fifo_rd_data = vecs[i].d; reg_ack = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_rd_en", i), fifo_rd_en, vecs[i].rd_en);
      step();
      chk($sformatf("v%0d_req", i), reg_req, vecs[i].req);
      chk($sformatf("v%0d_err", i), frame_err, vecs[i].err);
      chk($sformatf("v%0d_code", i), err_code, vecs[i].code);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_we", i), reg_we, vecs[i].we);
        chk($sformatf("v%0d_addr", i), reg_addr, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), reg_wdata, vecs[i].wd);
      end
    end
    reg_ack = 1'b0; fifo_valid = 1'b0;

    // Timeout after opcode: error on the 8th idle edge
    fifo_valid = 1'b1; fifo_rd_data = 8'hA5; step();
    fifo_rd_data = 8'h01; step();
    fifo_valid = 1'b0;
    wait_err("tmo_opc", 8);
    chk("tmo_opc_code", err_code, 2'd2);
    chk("tmo_opc_busy", busy, 1'b0);
    step();
    chk("tmo_opc_pulse", frame_err, 1'b0);

    // A byte consumed on the edge the timeout would fire rescues the frame
    fifo_valid = 1'b1; fifo_rd_data = 8'hA5; step();
    fifo_rd_data = 8'h01; step();
    fifo_valid = 1'b0;
    repeat (7) step();
    chk("tmo_pre_err", frame_err, 1'b0);
    fifo_valid = 1'b1; fifo_rd_data = 8'h44; step();
    chk("tmo_rescue_err", frame_err, 1'b0);
    chk("tmo_rescue_busy", busy, 1'b1);
    fifo_valid = 1'b0;
    wait_err("tmo_data", 8);
    chk("tmo_data_code", err_code, 2'd2);

    // Reset mid-frame: no error, everything back to reset values
    fifo_valid = 1'b1;
    fifo_rd_data = 8'hA5; step();
    fifo_rd_data = 8'h01; step();
    fifo_rd_data = 8'h50; step();
    fifo_rd_data = 8'hDE; step();
    fifo_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk("rst_req", reg_req, 1'b0);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 32'h0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_code", err_code, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (frame_err !== 1'b0 || busy !== 1'b0) k++;
    end
    chk("rst_quiet", k, 0);

    // Reset while a request is pending
    fifo_valid = 1'b1;
    fifo_rd_data = 8'hA5; step();
    fifo_rd_data = 8'h02; step();
    fifo_rd_data = 8'h3C; step();
    fifo_valid = 1'b0;
    chk("rst_issue_pre", reg_req, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_issue_req", reg_req, 1'b0);
    chk("rst_issue_busy", busy, 1'b0);

    // Back-pressure: write then read queued; ack withheld for 20 cycles
    q = '{8'hA5, 8'h01, 8'h77, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h02, 8'h99};
    fifo_valid = 1'b1; fifo_rd_data = q[0]; #1;
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      qstep();
      if (reg_req === 1'b1) begin k = i; break; end
    end
    chk("bp_latency", k, 7);
    chk("bp_we", reg_we, 1'b1);
    chk("bp_addr", reg_addr, 8'h77);
    chk("bp_wdata", reg_wdata, 32'h11223344);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_rd_en_%0d", i), fifo_rd_en, 1'b0);
      chk($sformatf("bp_hold_%0d", i), {reg_req, reg_we, reg_addr, reg_wdata[21:0]},
          {1'b1, 1'b1, 8'h77, 22'h223344});
      qstep();
    end
    chk("bp_wdata_hi", reg_wdata[31:22], 10'h044);
    chk("bp_queue_left", q.size(), 3);
    reg_ack = 1'b1; qstep(); reg_ack = 1'b0;
    chk("bp_req_drop", reg_req, 1'b0);
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      qstep();
      if (reg_req === 1'b1) begin k = i; break; end
    end
    chk("bp_second_latency", k, 3);
    chk("bp_second_we", reg_we, 1'b0);
    chk("bp_second_addr", reg_addr, 8'h99);
    chk("bp_second_wdata", reg_wdata, 32'h0);
    chk("bp_queue_empty", q.size(), 0);
    reg_ack = 1'b1; qstep(); reg_ack = 1'b0;
    chk("bp_final_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
